// File: rtl/ula_arbiter_if.sv
// rtl/ula_arbiter_if.sv - request/grant bundle between requesters and the ALU select arbiter
interface ula_arbiter_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;

   modport master (output req, input gnt, input sel, input busy);
   modport slave  (input req, output gnt, output sel, output busy);
endinterface

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - round-robin owner arbiter for the ALU result mux with bounded hold time
module ula_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input logic          clk,
   input logic          rst,
   ula_arbiter_if.slave bus
);

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q,   ptr_d;
   logic [3:0] cnt_q,   cnt_d;
   logic [7:0] gnt_q,   gnt_d;
   logic [2:0] sel_q,   sel_d;

   logic       release_w;
   logic [2:0] search_start;
   logic       found;
   logic [2:0] found_idx;

   // An owner gives up the mux when it drops its request or has used its full hold budget.
   assign release_w = (state_q == GRANT) && (!bus.req[sel_q] || (cnt_q == MAX_HOLD_C));

   // On release the search begins just past the outgoing owner, so it sees the updated pointer in the same edge.
   assign search_start = release_w ? (sel_q + 3'd1) : ptr_q;

   // Find the first requester at or after search_start, wrapping 7 -> 0.
   always_comb begin
      logic [2:0] idx;
      found     = 1'b0;
      found_idx = 3'd0;
      idx       = 3'd0;
      for (int i = 0; i < 8; i++) begin
         idx = search_start + i[2:0];
         if (!found && bus.req[idx]) begin
            found     = 1'b1;
            found_idx = idx;
         end
      end
   end

   // Next-state logic: grant from IDLE, hold/count in GRANT, hand over or go idle on release.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            gnt_d = 8'h00;
            cnt_d = 4'd0;
            if (found) begin
               state_d = GRANT;
               gnt_d   = 8'h01 << found_idx;
               sel_d   = found_idx;
               cnt_d   = 4'd1;
            end
         end
         GRANT: begin
            if (release_w) begin
               ptr_d = sel_q + 3'd1;
               if (found) begin
                  gnt_d = 8'h01 << found_idx;
                  sel_d = found_idx;
                  cnt_d = 4'd1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 8'h00;
                  cnt_d   = 4'd0;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 8'h00;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // State register; reset clears ownership and restarts the search at requester 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         cnt_q   <= 4'd0;
         gnt_q   <= 8'h00;
         sel_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.sel  = sel_q;
   assign bus.busy = |gnt_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - scoreboard bench for ula_arbiter with directed request vectors
module tb_ula_arbiter;

   logic clk;
   logic rst;

   ula_arbiter_if bus ();

   ula_arbiter #(.MAX_HOLD(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] sel;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   stim_done = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of stimulus and record what the outputs must show after the next edge.
   task automatic step(input logic r, input logic [7:0] rq,
                       input logic [7:0] eg, input logic [2:0] es, input string nm);
      exp_t e;
      @(negedge clk);
      rst     = r;
      bus.req = rq;
      e.gnt   = eg;
      e.sel   = es;
      e.name  = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: after every rising edge compare the presented outputs with the oldest expectation.
   initial begin
      exp_t e;
      logic exp_busy;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_busy = (e.gnt != 8'h00);
            checks++;
            if (bus.gnt !== e.gnt || bus.sel !== e.sel || bus.busy !== exp_busy
                || !$onehot0(bus.gnt)) begin
               failures++;
               $display("FAIL %s: got gnt=%h sel=%0d busy=%b, want gnt=%h sel=%0d busy=%b",
                        e.name, bus.gnt, bus.sel, bus.busy, e.gnt, e.sel, exp_busy);
            end
         end
      end
   end

   // Directed stimulus with hand-computed expectations (MAX_HOLD = 4).
   initial begin
      rst     = 1'b1;
      bus.req = 8'h00;

      step(1, 8'h00, 8'h00, 3'd0, "reset");
      step(1, 8'hFF, 8'h00, 3'd0, "reset_ignores_req");

      // Single requester 0, then drop -> idle with sel held.
      step(0, 8'h01, 8'h01, 3'd0, "first_grant");
      step(0, 8'h00, 8'h00, 3'd0, "drop_to_idle");

      // All requesting: every owner holds exactly 4 cycles, rotation wraps back to 0.
      step(1, 8'h00, 8'h00, 3'd0, "reset_ptr");
      for (int o = 0; o < 9; o++)
         for (int k = 0; k < 4; k++)
            step(0, 8'hFF, 8'h01 << (o % 8), 3'(o % 8), "rr_all");
      step(0, 8'h00, 8'h00, 3'd0, "rr_release_idle");

      // Owner 3 drops in its second cycle while 5 waits: immediate handover.
      step(1, 8'h00, 8'h00, 3'd0, "reset_b");
      step(0, 8'h08, 8'h08, 3'd3, "own3_c1");
      step(0, 8'h08, 8'h08, 3'd3, "own3_c2");
      step(0, 8'h20, 8'h20, 3'd5, "handover_5");
      step(0, 8'h20, 8'h20, 3'd5, "own5_c2");
      step(0, 8'h21, 8'h20, 3'd5, "no_preempt_c3");
      step(0, 8'h21, 8'h20, 3'd5, "no_preempt_c4");
      step(0, 8'h21, 8'h01, 3'd0, "expire_wrap_0");
      step(0, 8'h00, 8'h00, 3'd0, "idle_after_0");

      // Lone requester 6 held 10 cycles: continuous regrant on expiry.
      for (int k = 0; k < 10; k++)
         step(0, 8'h40, 8'h40, 3'd6, "lone_regrant");
      step(0, 8'h00, 8'h00, 3'd6, "idle_sel_held_6");

      // Owner 7 expires with requester 0 waiting: wrap to 0, then idle.
      for (int k = 0; k < 4; k++)
         step(0, 8'h81, 8'h80, 3'd7, "own7");
      step(0, 8'h81, 8'h01, 3'd0, "wrap_7_to_0");
      step(0, 8'h00, 8'h00, 3'd0, "idle_sel_0");

      // Reset mid-grant drops ownership; search restarts at 0.
      step(0, 8'h20, 8'h20, 3'd5, "own5_again");
      step(1, 8'h0C, 8'h00, 3'd0, "reset_midgrant");
      step(0, 8'h0C, 8'h04, 3'd2, "post_reset_grant");
      step(0, 8'h0C, 8'h04, 3'd2, "post_reset_hold");

      stim_done = 1;
   end

   // Finish once all expectations are consumed, bounded by a cycle budget.
   initial begin
      int cyc;
      cyc = 0;
      while (!(stim_done && exp_q.size() == 0) && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      #2;
      checks++;
      if (!(stim_done && exp_q.size() == 0)) begin
         failures++;
         $display("FAIL timeout: pending=%0d stim_done=%0d, want pending=0 stim_done=1",
                  exp_q.size(), stim_done);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ula_arbiter.md
ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, max consecutive cycles one requester may own the ALU select path; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: req  input  8  request lines; req[i] asserted = requester i wants the ALU result mux.
REQ-005 Port: gnt  output  8  one-hot grant, registered; gnt[i] = requester i owns the mux.
REQ-006 Port: sel  output  3  registered owner index; drives mux selects S2=sel[2], S1=sel[1], S0=sel[0].
REQ-007 Port: busy  output  1  high whenever any gnt bit is high.

Function
REQ-008 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-009 The block SHALL sample req only on rising clk edges; no combinational path from req to gnt/sel/busy.
REQ-010 The block SHALL keep a 3-bit round-robin pointer ptr; the search for a new owner starts at ptr and proceeds ptr, ptr+1, ..., wrapping 7->0.
REQ-011 IDLE: if any req bit is set at an edge, the first set bit in search order SHALL become owner at that edge (grant latency 1 cycle); otherwise remain IDLE with gnt=0.
REQ-012 GRANT: a 4-bit hold counter SHALL read 1 in the first owned cycle and increment each owned cycle.
REQ-013 GRANT release SHALL occur at the edge where req[owner]=0 is sampled, or where counter = MAX_HOLD, whichever first.
REQ-014 On release, ptr SHALL become (owner+1) mod 8 and the search SHALL run in the same edge with the updated ptr; a found requester is granted with no idle cycle and counter reset to 1.
REQ-015 On release by expiry with req[owner] still set and no other request, the same owner SHALL be regranted with counter reset to 1 (gnt stays continuous).
REQ-016 On release with no request set, the FSM SHALL enter IDLE, gnt=0, busy=0.
REQ-017 Non-owner req changes SHALL never preempt the current owner.
REQ-018 gnt SHALL be one-hot or zero at all times; sel SHALL equal the index of the set gnt bit while busy=1.
REQ-019 In IDLE, sel SHALL hold the last owner index (0 if none since reset).
REQ-020 The counter SHALL never exceed MAX_HOLD; no wrap of the counter is permitted.

Reset
REQ-021 While rst=1 at an edge: state=IDLE, gnt=8'h00, sel=3'd0, busy=0, ptr=0, counter=0; req ignored.
REQ-022 rst asserted mid-grant SHALL drop gnt at that edge; first post-reset search starts at requester 0.
REQ-023 Arbitration SHALL resume at the first edge with rst=0 (grant visible one cycle after that edge).

Verification
REQ-024 Reset, then req=8'h01 -> next cycle gnt=8'h01, sel=0, busy=1.
REQ-025 MAX_HOLD=4, req=8'hFF held -> owners 0,1,...,7,0 each exactly 4 cycles, no gnt=0 cycle between.
REQ-026 Owner 3, req[3] drops in its 2nd owned cycle with req=8'h20 -> at that edge gnt=8'h20, sel=5, no bubble.
REQ-027 req=8'h40 held 10 cycles -> gnt=8'h40 continuously for all 10 cycles, counter cycles 1..4,1..4,1..2.
REQ-028 Owner 7 expires with req=8'h81 -> next gnt=8'h01, sel=0 (wrap-around); then req=8'h00 on release -> gnt=0, busy=0, sel=0 held.
REQ-029 rst=1 during owner 5 with req=8'h0C -> gnt=0, sel=0; after rst=0 -> gnt=8'h04, sel=2.
